// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave front-end.
//   - spi_state_t : slave FSM states
//   - OP_*        : opcode values carried in the top two frame bits
//   - DATA_W_DEF  : default payload width; FRAME_W is the matching frame width
//   - frame_width : frame width for an arbitrary payload width
package spi_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int FRAME_W    = DATA_W_DEF + 2;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    WAIT_TX,
    SEND
  } spi_state_t;

  function automatic int frame_width(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// spi_tx_serializer: parallel-load, MSB-first shift register driving MISO.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   clear        : synchronous clear (transaction aborted)
//   load, data   : load a byte; its MSB appears on miso right after this edge
//   shift        : advance one bit per cycle; miso returns to 0 after the LSB
//   miso         : registered serial output, 0 whenever nothing is being sent
module spi_tx_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] data,
  output logic              miso
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  left;    // bits still to be presented after the current one

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      shreg <= '0;
      left  <= '0;
      miso  <= 1'b0;
    end else if (load) begin
      // MSB goes straight to the output register so it is visible one cycle
      // after the load edge; the remainder waits in shreg.
      miso  <= data[DATA_W-1];
      shreg <= {data[DATA_W-2:0], 1'b0};
      left  <= CNT_W'(DATA_W - 1);
    end else if (shift && left != '0) begin
      miso  <= shreg[DATA_W-1];
      shreg <= {shreg[DATA_W-2:0], 1'b0};
      left  <= left - 1'b1;
    end else begin
      miso  <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI slave front-end for the single-port SPI RAM (SPI clock = clk).
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   SS_n              : slave select, active-low; high aborts any transaction
//   MOSI / MISO       : serial in / out, MSB first
//   rx_data, rx_valid : completed frame {opcode[1:0], payload} with 1-cycle strobe
//   tx_data, tx_valid : read byte returned by the RAM
// Build option: define SPI_CMD_CHECK_EN to drop frames whose opcode disagrees
// with the command bit / read phase (no strobe, rd_addr_seen untouched).
module spi_slave import spi_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SS_n,
  input  logic                MOSI,
  output logic                MISO,
  output logic [DATA_W+1:0]   rx_data,
  output logic                rx_valid,
  input  logic [DATA_W-1:0]   tx_data,
  input  logic                tx_valid
);

  localparam int FW    = frame_width(DATA_W);
  localparam int CNT_W = $clog2(FW + 1);

  spi_state_t       state;
  logic [CNT_W-1:0] bit_cnt;       // frame bits received; FW means frame done
  logic [FW-2:0]    rx_shift;      // all but the last frame bit
  logic             rd_addr_seen;  // a read address is pending its data phase
  logic [FW-1:0]    frame_word;    // full frame as of the edge sampling bit 0
  logic             frame_ok;
  logic             tx_load;
  logic             tx_shift;

  assign frame_word = {rx_shift, MOSI};

`ifdef SPI_CMD_CHECK_EN
  logic cmd_bit;
  // The command bit is implied by the data state: only WRITE came from a 0.
  assign cmd_bit = (state != WRITE);

  always_comb begin
    frame_ok = (frame_word[FW-1] == cmd_bit);
    if (state == READ_ADD && frame_word[FW-2] != OP_RD_ADDR[0])
      frame_ok = 1'b0;
    if (state == READ_DATA && frame_word[FW-2] != OP_RD_DATA[0])
      frame_ok = 1'b0;
  end
`else
  assign frame_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      rd_addr_seen <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        // Abort: partial frame discarded, rx_data keeps its last good value.
        state    <= IDLE;
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else begin
        case (state)
          IDLE: state <= CHK_CMD;
          CHK_CMD: begin
            if (!MOSI)
              state <= WRITE;
            else if (rd_addr_seen)
              state <= READ_DATA;
            else
              state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (bit_cnt != CNT_W'(FW)) begin
              rx_shift <= {rx_shift[FW-3:0], MOSI};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(FW - 1)) begin
                if (frame_ok) begin
                  rx_data  <= frame_word;
                  rx_valid <= 1'b1;
                  if (state == READ_ADD)
                    rd_addr_seen <= 1'b1;
                  if (state == READ_DATA)
                    rd_addr_seen <= 1'b0;
                end
                // Write/read-addr frames park here until SS_n rises.
                if (state == READ_DATA)
                  state <= WAIT_TX;
              end
            end
          end
          WAIT_TX: if (tx_valid) state <= SEND;
          SEND: state <= SEND;  // holds until SS_n rises
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign tx_load  = (state == WAIT_TX) && !SS_n && tx_valid;
  assign tx_shift = (state == SEND);

  spi_tx_serializer #(.DATA_W(DATA_W)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (SS_n),
    .load  (tx_load),
    .shift (tx_shift),
    .data  (tx_data),
    .miso  (MISO)
  );

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: scoreboard bench for spi_slave. A driver issues whole SPI
// transactions edge by edge; a transaction-level reference model predicts the
// frames the RAM should receive and the MISO bit after every edge. A monitor
// compares DUT outputs against those queues. A small RAM model answers
// read-data frames one cycle later, as the real RAM does.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  always #5 clk = ~clk;

  spi_slave #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] word;
    int         due;
  } rx_exp_t;

  rx_exp_t    rx_q[$];
  bit         miso_q[$];

  // reference model state
  bit         ref_seen;
  logic [7:0] ref_mem[256];
  logic [7:0] ref_wa, ref_ra;

  // RAM device model state
  logic [7:0] ram_mem[256];
  logic [7:0] ram_wa, ram_ra;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // one clock edge: inputs set on the falling edge, expected MISO after the edge
  task automatic step(input bit ss, input bit mosi, input bit rst, input bit exp_miso);
    @(negedge clk);
    SS_n  = ss;
    MOSI  = mosi;
    rst_n = !rst;
    miso_q.push_back(exp_miso);
  endtask

  task automatic ref_apply(input logic [9:0] w);
    case (w[9:8])
      2'b00: ref_wa = w[7:0];
      2'b01: ref_mem[ref_wa] = w[7:0];
      2'b10: ref_ra = w[7:0];
      default: ;
    endcase
  endtask

  // abort_bits >= 0: SS_n rises after that many frame bits.
  // hold > 0: number of edges SS_n stays low (>= 12). rst_at >= 12: reset on that edge.
  task automatic xfer(input bit cmd, input logic [9:0] w, input int abort_bits,
                      input int hold, input int rst_at);
    int path;  // 0 write, 1 read address, 2 read data
    bit drop, done, sending, m, e;
    int low, gap;
    logic [7:0] byte_v;
    path = !cmd ? 0 : (ref_seen ? 2 : 1);
    drop = 1'b0;
`ifdef SPI_CMD_CHECK_EN
    drop = (w[9] != cmd) || (path == 1 && w[8]) || (path == 2 && !w[8]);
`endif
    sending = (path == 2) && !drop && (w[9:8] == 2'b11);
    if (abort_bits >= 0)
      low = 2 + abort_bits;
    else if (hold > 0)
      low = hold;
    else
      low = sending ? 21 : 12;
    done = (low >= 12) && (rst_at < 0 || rst_at > 11);
    sending = sending && done;
    byte_v = ref_mem[ref_ra];
    $display("xfer cmd=%0d word=%03h path=%0d drop=%0d low=%0d rst_at=%0d",
             cmd, w, path, drop, low, rst_at);
    for (int k = 0; k < low; k++) begin
      if (k == 1)
        m = cmd;
      else if (k >= 2 && k <= 11)
        m = w[11-k];
      else
        m = 1'($urandom);
      e = (sending && k >= 13 && k <= 20) ? byte_v[20-k] : 1'b0;
      if (k == rst_at) begin
        step(1'b0, m, 1'b1, 1'b0);
        ref_seen = 1'b0;
        break;
      end
      step(1'b0, m, 1'b0, e);
      if (k == 11 && done && !drop) begin
        rx_q.push_back('{w, cyc + 1});
        ref_apply(w);
        if (path == 1) ref_seen = 1'b1;
        if (path == 2) ref_seen = 1'b0;
      end
    end
    gap = 1 + $urandom_range(0, 2);
    for (int g = 0; g < gap; g++)
      step(1'b1, 1'($urandom), 1'b0, 1'b0);
  endtask

  // monitor: compares whatever the DUT presents against the scoreboard queues
  initial begin
    rx_exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (miso_q.size() != 0)
        chk("miso", 32'(MISO), 32'(miso_q.pop_front()));
      if (rx_valid) begin
        if (rx_q.size() == 0) begin
          chk("rx_valid_spurious", 32'(rx_valid), 32'd0);
        end else begin
          ex = rx_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(ex.word));
          chk("rx_valid_cycle", 32'(cyc), 32'(ex.due));
        end
      end else if (rx_q.size() != 0 && cyc > rx_q[0].due) begin
        chk("rx_valid_missing", 32'(rx_valid), 32'd1);
        void'(rx_q.pop_front());
      end
    end
  end

  // RAM device: 1-cycle read latency on read-data frames
  initial begin
    tx_valid = 1'b0;
    tx_data  = '0;
    ram_wa   = '0;
    ram_ra   = '0;
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        case (rx_data[9:8])
          2'b00: ram_wa = rx_data[7:0];
          2'b01: ram_mem[ram_wa] = rx_data[7:0];
          2'b10: ram_ra = rx_data[7:0];
          default: begin
            @(posedge clk);
            #1;
            tx_valid = 1'b1;
            tx_data  = ram_mem[ram_ra];
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
          end
        endcase
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] op;
    bit         rcmd;
    logic [9:0] rw;
    int         ab, hd;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      ram_mem[i] = '0;
    end
    ref_wa = '0;
    ref_ra = '0;
    ref_seen = 1'b0;

    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("reset_miso", 32'(MISO), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    xfer(1'b0, 10'h03C, -1, 0, -1);   // write address
    xfer(1'b0, 10'h1A5, -1, 0, -1);   // write data
    xfer(1'b1, 10'h23C, -1, 0, -1);   // read address
    xfer(1'b1, 10'h300, -1, 0, -1);   // read data -> A5 on MISO
    xfer(1'b0, 10'h1FF, 5, 0, -1);    // abort after 5 frame bits
    xfer(1'b0, 10'h055, -1, 0, -1);   // next frame decodes normally
    xfer(1'b1, 10'h23C, -1, 0, -1);
    xfer(1'b1, 10'h300, -1, 24, -1);  // SS_n held past the last bit
    xfer(1'b1, 10'h23C, -1, 0, -1);
    xfer(1'b1, 10'h300, -1, 12, -1);  // SS_n rises before the RAM answers
    xfer(1'b1, 10'h23C, -1, 0, -1);
    xfer(1'b1, 10'h300, -1, 13, -1);  // SS_n rises in WAIT_TX

    // read command straight after reset takes the address path
    step(1'b1, 1'b0, 1'b1, 1'b0);
    ref_seen = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, 10'h0FF, -1, 0, -1);
    xfer(1'b1, 10'h300, -1, 0, -1);

    // reset mid-SEND, then a read command must start a fresh address phase
    xfer(1'b1, 10'h23C, -1, 0, -1);
    xfer(1'b1, 10'h300, -1, 0, 16);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    xfer(1'b1, 10'h300, -1, 0, -1);

    // reset while a read address is pending clears it
    xfer(1'b1, 10'h23C, -1, 0, -1);
    xfer(1'b0, 10'h03C, -1, 20, 15);
    xfer(1'b1, 10'h300, -1, 0, -1);

    for (int t = 0; t < 40; t++) begin
      op = 2'($urandom_range(0, 3));
      rcmd = op[1];
      if ($urandom_range(0, 9) == 0) rcmd = !rcmd;
      rw = {op, (op[0] == 1'b0) ? 8'($urandom_range(0, 3)) : 8'($urandom)};
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1;
      hd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 24)) : 0;
      xfer(rcmd, rw, ab, hd, -1);
    end

    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rx_queue_drained", 32'(rx_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

Serial front-end for the single-port SPI RAM. It deserialises MOSI into the 10-bit command/data words the RAM consumes on `rx_data`/`rx_valid`. It also serialises the RAM's read byte (`tx_data`/`tx_valid`) back onto MISO. The block sits directly upstream of the RAM, and both run on the common system clock, which doubles as the SPI clock.

## Interface
Parameters:
- `DATA_W`, default 8: payload width. The frame is `DATA_W+2` bits: 2 opcode bits plus payload.

Ports:
- `clk`, in, 1: system/SPI clock. All sampling is on the rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `SS_n`, in, 1: slave select, active-low. High aborts any transaction.
- `MOSI`, in, 1: serial in, MSB first.
- `MISO`, out, 1: serial out, MSB first.
- `rx_data`, out, `DATA_W+2`: completed frame to the RAM. Bits [9:8] are the opcode: 00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- `rx_valid`, out, 1: one-cycle strobe qualifying `rx_data`.
- `tx_data`, in, `DATA_W`: read byte from the RAM.
- `tx_valid`, in, 1: qualifies `tx_data`.

## Operation
- **States:**
  - IDLE
  - CHK_CMD
  - WRITE
  - READ_ADD
  - READ_DATA
  - WAIT_TX
  - SEND
- **IDLE → CHK_CMD** when `SS_n`=0 is sampled. MOSI is ignored on that edge.
- **CHK_CMD** samples the command bit from MOSI:
  - 0 → WRITE.
  - 1 → READ_ADD if `rd_addr_seen`=0, else READ_DATA.
- **WRITE / READ_ADD / READ_DATA:** a 4-bit counter shifts in exactly 10 bits, MSB first.
  - On the edge sampling bit 0, `rx_data` is loaded with the full word and `rx_valid` is registered to 1 for exactly one cycle.
  - The FSM then parks in the same state. WRITE and READ_ADD wait there for `SS_n`=1; READ_DATA moves to WAIT_TX.
- **`rd_addr_seen` flag:**
  - Set when a READ_ADD frame completes.
  - Cleared when a READ_DATA frame completes.
  - Unaffected by WRITE frames and by aborts.
- **WAIT_TX:** on the first edge with `tx_valid`=1, latch `tx_data` into the output shift register → SEND.
- **SEND:**
  - MISO carries `tx_data[7]` through `tx_data[0]`, one bit per cycle.
  - After bit 0, MISO returns to 0 and the FSM holds until `SS_n`=1.
- **Idle MISO:** 0 whenever not in SEND.
- **Abort:** `SS_n`=1 sampled in any state → IDLE on that edge.
  - Bit counter and shift registers are cleared.
  - No `rx_valid` is produced for a partial frame.
  - `rx_data` retains its last completed value.
- **Frame content:** the opcode bits are forwarded unchanged. The command bit selects only the FSM path (see Configuration).
- **Mid-operation reset:** `rst_n`=0 on any edge forces the reset state next cycle, regardless of `SS_n`.

## Timing
- **Reset values:** `MISO`=0, `rx_data`=0, `rx_valid`=0, state=IDLE, `rd_addr_seen`=0, counter=0.
- **Edge numbering:** edge 0 is the first edge with `SS_n`=0.
  - Edge 1: command bit.
  - Edges 2–11: frame bits 9..0.
  - `rx_valid` is high in the cycle after edge 11.
- **Read-data turnaround** (RAM has 1-cycle latency):
  - RAM samples `rx_valid` at edge 12 and raises `tx_valid` after edge 12.
  - The slave latches `tx_data` at edge 13.
  - MISO shows bit 7 after edge 13, through bit 0 after edge 20.
  - The master keeps `SS_n` low through edge 20, i.e. for 21 edges.
- **Other frames:** write and read-addr frames need `SS_n` low for 12 edges.
- **`tx_valid` outside WAIT_TX:** ignored.
- **`SS_n` high in WAIT_TX:** the slave abandons the read and the late `tx_valid` is ignored.

## Configuration
- **`SPI_CMD_CHECK_EN` defined:** a completed frame is dropped (no `rx_valid`, FSM state still advances to park) if:
  - `rx_data[9]` ≠ command bit, or
  - a READ_ADD frame has `rx_data[8]`≠0, or
  - a READ_DATA frame has `rx_data[8]`≠1.

  A dropped frame leaves `rd_addr_seen` unchanged.
- **Undefined:** no checking. Every completed frame strobes `rx_valid`.

## Structure
- **Package `spi_pkg`:**
  - State enum.
  - Opcode constants `OP_WR_ADDR`=2'b00, `OP_WR_DATA`=2'b01, `OP_RD_ADDR`=2'b10, `OP_RD_DATA`=2'b11.
  - `FRAME_W` = `DATA_W`+2.
- **Sub-module `spi_tx_serializer`:** load/shift register with bit counter, driving MISO. The FSM and the deserialiser stay in `spi_slave`.

## Test plan
- Write address: reset, then `SS_n`=0, command 0, bits 00_0x3C → `rx_valid` one cycle after edge 11 with `rx_data`=10'h03C; MISO stays 0.
- Write data: frame 01_0xA5 → `rx_data`=10'h1A5 with a single-cycle `rx_valid`.
- Read sequence:
  - Read address 10_0x3C → `rd_addr_seen`=1.
  - Read data 11_0x00, with a RAM model returning 0xA5 one cycle later → MISO = 1,0,1,0,0,1,0,1 after edges 13–20; `rd_addr_seen`=0.
- Abort: `SS_n` high after 5 data bits → no `rx_valid`, IDLE next cycle; the following complete frame decodes correctly.
- Read without a prior address: command 1 on a fresh reset → READ_ADD path taken. With `SPI_CMD_CHECK_EN`, frame 0x0FF with command 1 is dropped.
- Reset mid-SEND (after edge 16) → MISO=0 and state IDLE next cycle; `rd_addr_seen`=0.
